cgram_access_scheduler: RTL and testbench
=========================================

# cgram_access_scheduler

Time-multiplexes the single-port 256×15 CGRAM between three requesters: main-screen palette lookup, sub-screen palette lookup and the CPU register port ($2121 CGADD, $2122 CGDATA, $213B CGDATAREAD). It sits between the pixel mixer and the CGRAM macro. The palette indices chosen by the mixer's reference-palette selection arrive as `main_idx`/`sub_idx`, and the block returns 15-bit BGR colours per dot. CPU accesses are queued and granted only in slots that do not disturb display lookups.

## Interface
- `DOT_CLKS`, 4: clk cycles per dot; fixed at 4, and the slot counter is 2 bits wide.
- `clk`  in  1  PPU clock.
- `reset_n`  in  1  synchronous, active-low reset.
- `dot_en`  in  1  one-cycle pulse per dot; marks slot 0.
- `display_active`  in  1  1 while inside the visible area and not in force-blank.
- `main_idx`  in  8  main-screen CGRAM index, stable through slot 0.
- `sub_idx`  in  8  sub-screen CGRAM index, stable through slot 1.
- `main_color`  out  15  main-screen colour of the last completed dot.
- `sub_color`  out  15  sub-screen colour of the last completed dot.
- `color_valid`  out  1  one-cycle pulse when both colours update.
- `cpu_we`  in  1  CPU register write strobe.
- `cpu_re`  in  1  CPU register read strobe.
- `cpu_reg`  in  2  register select: 0 = CGADD, 1 = CGDATA, 2 = CGDATAREAD; 3 is ignored.
- `cpu_wdata`  in  8  write data.
- `cpu_rdata`  out  8  read data, registered.
- `cpu_busy`  out  1  a CPU RAM operation is pending; strobes are ignored while it is high.
- `cg_addr`  out  8  CGRAM address.
- `cg_we`  out  1  CGRAM write enable.
- `cg_wdata`  out  15  CGRAM write data.
- `cg_rdata`  in  15  CGRAM read data, valid 1 cycle after the address.

## Operation
- **Slot counter**
  - Forced to 0 in any cycle where `dot_en` is high; increments mod 4 otherwise.
  - The slot counter runs regardless of `display_active`.
- **Display active, sampled in slot 0 and held for the dot**
  - Slot 0: `cg_addr` = `main_idx`.
  - Slot 1: `cg_addr` = `sub_idx`; capture `cg_rdata` into the main hold register.
  - Slot 2: capture `cg_rdata` into the sub hold register. Both hold registers transfer to `main_color`/`sub_color` at the end of slot 2.
  - Slot 3: `color_valid` = 1.
  - The CPU grant is in slot 2 only.
- **Display inactive**
  - No lookups are issued.
  - `main_color`/`sub_color` hold their values and `color_valid` stays 0.
  - The CPU is granted in any cycle.
- **CPU register semantics**
  - The block keeps a word address `wa[7:0]`, a byte flip `flip` shared by reads and writes, a write-low latch, and a 15-bit read buffer `rbuf`.
  - CGADD write: `wa` ← `cpu_wdata`, `flip` ← 0, queue PREFETCH.
  - CGDATA write with `flip`=0: latch the low byte, `flip` ← 1.
  - CGDATA write with `flip`=1: queue WRITE of {`cpu_wdata[6:0]`, low} to `wa`; `wa` ← `wa`+1 (255 wraps to 0); `flip` ← 0.
  - CGDATAREAD with `flip`=0: `cpu_rdata` ← `rbuf[7:0]`, `flip` ← 1.
  - CGDATAREAD with `flip`=1: `cpu_rdata` ← {0, `rbuf[14:8]`}; `wa` ← `wa`+1; `flip` ← 0; queue PREFETCH.
  - After a write, `rbuf` is stale until the next PREFETCH; that behaviour is intended.
- **CPU operation FSM**
  - IDLE → WAIT_GRANT when an operation is queued; `cpu_busy` = 1 in every state except IDLE.
  - WAIT_GRANT, on grant with WRITE: `cg_addr` = target, `cg_we` = 1, `cg_wdata` = word, → IDLE.
  - WAIT_GRANT, on grant with PREFETCH: `cg_addr` = `wa`, → RD_CAPTURE.
  - RD_CAPTURE: `rbuf` ← `cg_rdata`, → IDLE.
- **Boundary cases**
  - Strobes while `cpu_busy` = 1 are dropped, with no state change.
  - `cpu_we` and `cpu_re` high in the same cycle: the write wins and the read is dropped.
  - If `display_active` rises while the FSM is in RD_CAPTURE, the capture still completes, because the returned data lands in the slot-0 cycle, before the main lookup data.
  - `cg_we` is never asserted in slots 0 or 1 while the display is active.

## Timing
- Reset values: all outputs 0, `wa` 0, `flip` 0, `rbuf` 0, slot 0, FSM IDLE.
- Reset mid-operation abandons any queued WRITE; no `cg_we` is asserted in the reset cycle.
- Lookup latency: from the `dot_en` cycle to the `color_valid` pulse is 3 cycles.
- CPU register effects (`wa`, `flip`, latch, queue) take effect on the edge that samples the strobe; `cpu_rdata` updates 1 cycle later.
- Worst-case CPU operation while the display is active:
  - WRITE: 4 cycles from queue to `cg_we`.
  - PREFETCH: 4 cycles plus 1 capture cycle.
- CPU operation with the display inactive: issued the cycle after it is queued.

## Structure
- Belongs in `ppu_pkg`:
  - `cg_op_type` enum (NONE, WRITE, PREFETCH).
  - `cg_fsm_type` enum (IDLE, WAIT_GRANT, RD_CAPTURE).
  - Register-select constants CG_REG_ADDR, CG_REG_DATA, CG_REG_READ.
  - The slot index constants.
- Sub-module `cgram_cpu_port` holds the CPU register decoding, `wa`/`flip`/latch/`rbuf` and the FSM. It exposes `req`/`op`/`addr`/`word` and takes `grant` as an input.
- The top level holds the slot counter, the grant logic, the address/write-enable mux and the colour registers.

## Test plan
- **Active-display lookup:** display active, `main_idx`=0x12, `sub_idx`=0x34, RAM[0x12]=0x7FFF, RAM[0x34]=0x001F, pulse `dot_en` → `main_color`=0x7FFF and `sub_color`=0x001F, with `color_valid` high exactly 3 cycles after `dot_en`.
- **Write sequence with wrap:** CGADD←0xFF, CGDATA←0x34, CGDATA←0xF2 → RAM[0xFF]=0x7234 with `cg_we` only in a granted slot; then `wa`=0x00 and `flip`=0.
- **Read sequence:** RAM[0x05]=0x5A3C; CGADD←0x05, wait until `cpu_busy` is low; read CGDATAREAD twice → 0x3C then 0x5A; a PREFETCH of 0x06 follows.
- **Write during active display:** CGDATA high-byte write queued while the display is active → `cg_we` is asserted only in slot 2, and the colours of that dot and the next are correct.
- **Busy and collision handling:** a strobe while `cpu_busy`=1 → ignored, `wa` unchanged. `cpu_we` and `cpu_re` together → only the write takes effect.
- **Reset mid-operation:** assert `reset_n`=0 while WAIT_GRANT holds a queued WRITE → no `cg_we`, and all outputs are 0 on the next cycle.

Source files
------------

// File: rtl/ppu_pkg.sv
// Shared PPU types and constants for the CGRAM access path.
// Slot indices, CPU register selects and the CPU operation/FSM encodings.
package ppu_pkg;

    localparam int DOT_CLKS = 4;

    localparam logic [1:0] SLOT_MAIN  = 2'd0;
    localparam logic [1:0] SLOT_SUB   = 2'd1;
    localparam logic [1:0] SLOT_CPU   = 2'd2;
    localparam logic [1:0] SLOT_VALID = 2'd3;

    localparam logic [1:0] CG_REG_ADDR = 2'd0;
    localparam logic [1:0] CG_REG_DATA = 2'd1;
    localparam logic [1:0] CG_REG_READ = 2'd2;

    typedef enum logic [1:0] {
        OP_NONE     = 2'd0,
        OP_WRITE    = 2'd1,
        OP_PREFETCH = 2'd2
    } cg_op_type;

    typedef enum logic [1:0] {
        ST_IDLE       = 2'd0,
        ST_WAIT_GRANT = 2'd1,
        ST_RD_CAPTURE = 2'd2
    } cg_fsm_type;

endpackage

// File: rtl/cgram_cpu_port.sv
// CPU side of CGRAM: CGADD/CGDATA/CGDATAREAD decoding, address/flip state,
// read buffer and the single-operation queue that waits for a RAM grant.
module cgram_cpu_port
    import ppu_pkg::*;
(
    input  logic        clk,
    input  logic        reset_n,
    input  logic        cpu_we,
    input  logic        cpu_re,
    input  logic [1:0]  cpu_reg,
    input  logic [7:0]  cpu_wdata,
    output logic [7:0]  cpu_rdata,
    output logic        cpu_busy,
    output logic        req,
    output logic [1:0]  op,
    output logic [7:0]  addr,
    output logic [14:0] word,
    input  logic        grant,
    input  logic [14:0] cg_rdata
);

    cg_fsm_type state;
    cg_op_type  op_q;
    logic [7:0]  wa;
    logic        flip;
    logic [7:0]  lo_byte;
    logic [14:0] rbuf;

    assign req      = (state == ST_WAIT_GRANT);
    assign cpu_busy = (state != ST_IDLE);
    assign op       = op_q;

    // NOTE: every register here is written with <= so all branches see pre-edge values.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state     <= ST_IDLE;
            op_q      <= OP_NONE;
            addr      <= '0;
            word      <= '0;
            wa        <= '0;
            flip      <= 1'b0;
            lo_byte   <= '0;
            rbuf      <= '0;
            cpu_rdata <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    // Strobes are only decoded here, so anything arriving while busy is dropped.
                    if (cpu_we) begin
                        case (cpu_reg)
                            CG_REG_ADDR: begin
                                wa    <= cpu_wdata;
                                flip  <= 1'b0;
                                addr  <= cpu_wdata;
                                op_q  <= OP_PREFETCH;
                                state <= ST_WAIT_GRANT;
                            end
                            CG_REG_DATA: begin
                                if (!flip) begin
                                    lo_byte <= cpu_wdata;
                                    flip    <= 1'b1;
                                end else begin
                                    addr  <= wa;
                                    word  <= {cpu_wdata[6:0], lo_byte};
                                    wa    <= wa + 8'd1;
                                    flip  <= 1'b0;
                                    op_q  <= OP_WRITE;
                                    state <= ST_WAIT_GRANT;
                                end
                            end
                            default: ;
                        endcase
                    end else if (cpu_re && cpu_reg == CG_REG_READ) begin
                        if (!flip) begin
                            cpu_rdata <= rbuf[7:0];
                            flip      <= 1'b1;
                        end else begin
                            cpu_rdata <= {1'b0, rbuf[14:8]};
                            wa        <= wa + 8'd1;
                            addr      <= wa + 8'd1;
                            flip      <= 1'b0;
                            op_q      <= OP_PREFETCH;
                            state     <= ST_WAIT_GRANT;
                        end
                    end
                end
                ST_WAIT_GRANT: begin
                    if (grant) begin
                        if (op_q == OP_WRITE) begin
                            op_q  <= OP_NONE;
                            state <= ST_IDLE;
                        end else begin
                            state <= ST_RD_CAPTURE;
                        end
                    end
                end
                ST_RD_CAPTURE: begin
                    rbuf  <= cg_rdata;
                    op_q  <= OP_NONE;
                    state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: rtl/cgram_access_scheduler.sv
// Time-multiplexes the single-port CGRAM between main/sub palette lookups and
// the CPU register port using a 4-slot per-dot schedule.
module cgram_access_scheduler
    import ppu_pkg::*;
(
    input  logic        clk,
    input  logic        reset_n,
    input  logic        dot_en,
    input  logic        display_active,
    input  logic [7:0]  main_idx,
    input  logic [7:0]  sub_idx,
    output logic [14:0] main_color,
    output logic [14:0] sub_color,
    output logic        color_valid,
    input  logic        cpu_we,
    input  logic        cpu_re,
    input  logic [1:0]  cpu_reg,
    input  logic [7:0]  cpu_wdata,
    output logic [7:0]  cpu_rdata,
    output logic        cpu_busy,
    output logic [7:0]  cg_addr,
    output logic        cg_we,
    output logic [14:0] cg_wdata,
    input  logic [14:0] cg_rdata
);

    logic [1:0]  slot_cnt;
    logic [1:0]  slot;
    logic        disp_hold;
    logic        active;
    logic        grant;
    logic [14:0] main_hold;

    logic        cpu_req;
    logic [1:0]  cpu_op;
    logic [7:0]  cpu_addr;
    logic [14:0] cpu_word;

    // dot_en itself is slot 0; display state is frozen for the dot from that cycle.
    assign slot   = dot_en ? SLOT_MAIN : slot_cnt;
    assign active = (slot == SLOT_MAIN) ? display_active : disp_hold;
    assign grant  = !active || (slot == SLOT_CPU);

    cgram_cpu_port u_cpu_port (
        .clk       (clk),
        .reset_n   (reset_n),
        .cpu_we    (cpu_we),
        .cpu_re    (cpu_re),
        .cpu_reg   (cpu_reg),
        .cpu_wdata (cpu_wdata),
        .cpu_rdata (cpu_rdata),
        .cpu_busy  (cpu_busy),
        .req       (cpu_req),
        .op        (cpu_op),
        .addr      (cpu_addr),
        .word      (cpu_word),
        .grant     (grant),
        .cg_rdata  (cg_rdata)
    );

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            slot_cnt    <= '0;
            disp_hold   <= 1'b0;
            main_hold   <= '0;
            main_color  <= '0;
            sub_color   <= '0;
            color_valid <= 1'b0;
        end else begin
            slot_cnt    <= slot + 2'd1;
            disp_hold   <= active;
            color_valid <= active && (slot == SLOT_CPU);
            if (active && slot == SLOT_SUB)
                main_hold <= cg_rdata;
            // Sub data is on cg_rdata during slot 2, so it goes straight to the output.
            if (active && slot == SLOT_CPU) begin
                main_color <= main_hold;
                sub_color  <= cg_rdata;
            end
        end
    end

    // NOTE: defaults first so every path assigns every output and no latch is inferred.
    always_comb begin
        cg_addr  = '0;
        cg_we    = 1'b0;
        cg_wdata = '0;
        if (reset_n) begin
            if (active && slot == SLOT_MAIN) begin
                cg_addr = main_idx;
            end else if (active && slot == SLOT_SUB) begin
                cg_addr = sub_idx;
            end else if (grant && cpu_req) begin
                cg_addr = cpu_addr;
                if (cpu_op == OP_WRITE) begin
                    cg_we    = 1'b1;
                    cg_wdata = cpu_word;
                end
            end
        end
    end

endmodule

// File: tb/tb_cgram_access_scheduler.sv
// Directed bench for cgram_access_scheduler with a behavioural CGRAM and a
// free-running dot generator; all expected values are hand-computed constants.
module tb_cgram_access_scheduler;
    import ppu_pkg::*;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        dot_en = 1'b0;
    logic        display_active = 1'b0;
    logic [7:0]  main_idx = 8'h00;
    logic [7:0]  sub_idx = 8'h00;
    logic [14:0] main_color;
    logic [14:0] sub_color;
    logic        color_valid;
    logic        cpu_we = 1'b0;
    logic        cpu_re = 1'b0;
    logic [1:0]  cpu_reg = 2'd0;
    logic [7:0]  cpu_wdata = 8'h00;
    logic [7:0]  cpu_rdata;
    logic        cpu_busy;
    logic [7:0]  cg_addr;
    logic        cg_we;
    logic [14:0] cg_wdata;
    logic [14:0] cg_rdata = 15'h0;

    logic [14:0] mem [256];
    logic        pre_we = 1'b0;
    logic [7:0]  pre_addr = 8'h00;
    logic [14:0] pre_data = 15'h0;

    int          n_checks = 0;
    int          n_errors = 0;
    int          cyc = 0;
    logic        dots_on = 1'b0;
    logic        disp_req = 1'b0;
    logic        disp_dot = 1'b0;
    logic [1:0]  tb_slot = 2'd3;

    int          last_dot = 0;
    int          cv_count = 0;
    int          cv_lat = 0;
    int          wr_count = 0;
    int          wr_bad = 0;
    int          wr_cyc = 0;
    logic [7:0]  wr_addr = 8'h00;
    logic [14:0] wr_data = 15'h0;
    int          strobe_cyc = 0;

    cgram_access_scheduler dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .dot_en         (dot_en),
        .display_active (display_active),
        .main_idx       (main_idx),
        .sub_idx        (sub_idx),
        .main_color     (main_color),
        .sub_color      (sub_color),
        .color_valid    (color_valid),
        .cpu_we         (cpu_we),
        .cpu_re         (cpu_re),
        .cpu_reg        (cpu_reg),
        .cpu_wdata      (cpu_wdata),
        .cpu_rdata      (cpu_rdata),
        .cpu_busy       (cpu_busy),
        .cg_addr        (cg_addr),
        .cg_we          (cg_we),
        .cg_wdata       (cg_wdata),
        .cg_rdata       (cg_rdata)
    );

    always #5 clk = ~clk;

    // CGRAM macro: synchronous read, one-cycle latency; bench preload port has priority.
    always @(posedge clk) begin
        if (pre_we)
            mem[pre_addr] <= pre_data;
        else if (cg_we)
            mem[cg_addr] <= cg_wdata;
        cg_rdata <= mem[cg_addr];
    end

    // Dot generator: display state only changes on dot boundaries.
    always @(posedge clk) begin
        #1;
        cyc = cyc + 1;
        if (dots_on) begin
            tb_slot = tb_slot + 2'd1;
            dot_en  = (tb_slot == 2'd0);
            if (tb_slot == 2'd0) begin
                display_active = disp_req;
                disp_dot       = disp_req;
            end
        end else begin
            dot_en = 1'b0;
        end
    end

    always @(negedge clk) begin
        if (dot_en)
            last_dot = cyc;
        if (color_valid) begin
            cv_count = cv_count + 1;
            cv_lat   = cyc - last_dot;
        end
        if (cg_we) begin
            wr_count = wr_count + 1;
            wr_addr  = cg_addr;
            wr_data  = cg_wdata;
            wr_cyc   = cyc;
            if (dots_on && disp_dot && tb_slot != SLOT_CPU)
                wr_bad = wr_bad + 1;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic ram_load(input logic [7:0] a, input logic [14:0] d);
        pre_addr = a;
        pre_data = d;
        pre_we   = 1'b1;
        step();
        pre_we   = 1'b0;
    endtask

    task automatic cpu_op(input logic we, input logic re, input logic [1:0] rsel, input logic [7:0] d);
        cpu_we     = we;
        cpu_re     = re;
        cpu_reg    = rsel;
        cpu_wdata  = d;
        strobe_cyc = cyc;
        step();
        cpu_we = 1'b0;
        cpu_re = 1'b0;
    endtask

    task automatic wait_idle(input string tag);
        for (int i = 0; i < 40 && cpu_busy; i++)
            step();
        check(tag, 32'(cpu_busy), 32'd0);
    endtask

    task automatic wait_cv(input string tag);
        int n;
        n = cv_count;
        for (int i = 0; i < 12 && cv_count == n; i++)
            step();
        check(tag, 32'(cv_count != n), 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        int n;
        int nwr;

        // Reset with RAM preload
        ram_load(8'h12, 15'h7FFF);
        ram_load(8'h34, 15'h001F);
        ram_load(8'h05, 15'h5A3C);
        ram_load(8'h06, 15'h1234);
        ram_load(8'h80, 15'h0A0B);
        ram_load(8'h90, 15'h0C0D);
        check("rst main_color", 32'(main_color), 32'h0);
        check("rst sub_color", 32'(sub_color), 32'h0);
        check("rst color_valid", 32'(color_valid), 32'h0);
        check("rst cpu_rdata", 32'(cpu_rdata), 32'h0);
        check("rst cpu_busy", 32'(cpu_busy), 32'h0);
        check("rst cg_we", 32'(cg_we), 32'h0);
        check("rst cg_addr", 32'(cg_addr), 32'h0);
        reset_n = 1'b1;
        step();

        // Active-display lookup
        main_idx = 8'h12;
        sub_idx  = 8'h34;
        disp_req = 1'b1;
        tb_slot  = 2'd3;
        dots_on  = 1'b1;
        wait_cv("lookup cv");
        check("lookup latency", 32'(cv_lat), 32'd3);
        check("lookup main", 32'(main_color), 32'h7FFF);
        check("lookup sub", 32'(sub_color), 32'h001F);
        n = cv_count;
        repeat (8) step();
        check("cv one per dot", 32'(cv_count - n), 32'd2);

        // CPU write during active display: {0x2A[6:0], 0x55} -> 0x2A55 at 0x40
        cpu_op(1'b1, 1'b0, CG_REG_ADDR, 8'h40);
        wait_idle("act prefetch idle");
        cpu_op(1'b1, 1'b0, CG_REG_DATA, 8'h55);
        cpu_op(1'b1, 1'b0, CG_REG_DATA, 8'h2A);
        wait_idle("act write idle");
        check("act wr addr", 32'(wr_addr), 32'h40);
        check("act wr data", 32'(wr_data), 32'h2A55);
        check("act wr ram", 32'(mem[8'h40]), 32'h2A55);
        check("act wr latency", 32'((wr_cyc - strobe_cyc) >= 1 && (wr_cyc - strobe_cyc) <= 4), 32'd1);
        wait_cv("act cv a");
        check("act main a", 32'(main_color), 32'h7FFF);
        check("act sub a", 32'(sub_color), 32'h001F);
        wait_cv("act cv b");
        check("act main b", 32'(main_color), 32'h7FFF);
        check("act sub b", 32'(sub_color), 32'h001F);
        main_idx = 8'h40;
        sub_idx  = 8'h12;
        wait_cv("newidx cv");
        check("newidx main", 32'(main_color), 32'h2A55);
        check("newidx sub", 32'(sub_color), 32'h7FFF);

        // Display off: colours hold, no pulses
        disp_req = 1'b0;
        repeat (8) step();
        n = cv_count;
        repeat (8) step();
        check("inactive no cv", 32'(cv_count - n), 32'd0);
        check("inactive hold main", 32'(main_color), 32'h2A55);
        check("inactive hold sub", 32'(sub_color), 32'h7FFF);

        // Write sequence with wrap: {0xF2[6:0], 0x34} = 0x7234 at 0xFF
        cpu_op(1'b1, 1'b0, CG_REG_ADDR, 8'hFF);
        wait_idle("wrap prefetch idle");
        nwr = wr_count;
        cpu_op(1'b1, 1'b0, CG_REG_DATA, 8'h34);
        check("low byte not busy", 32'(cpu_busy), 32'd0);
        cpu_op(1'b1, 1'b0, CG_REG_DATA, 8'hF2);
        wait_idle("wrap write idle");
        check("wrap wr count", 32'(wr_count - nwr), 32'd1);
        check("wrap wr addr", 32'(wr_addr), 32'hFF);
        check("wrap wr data", 32'(wr_data), 32'h7234);
        check("wrap wr ram", 32'(mem[8'hFF]), 32'h7234);
        check("inactive wr next cycle", 32'(wr_cyc - strobe_cyc), 32'd1);
        cpu_op(1'b1, 1'b0, CG_REG_DATA, 8'h11);
        cpu_op(1'b1, 1'b0, CG_REG_DATA, 8'h01);
        wait_idle("wrap2 idle");
        check("wrap addr zero", 32'(wr_addr), 32'h00);
        check("wrap2 data", 32'(wr_data), 32'h0111);

        // Read sequence
        cpu_op(1'b1, 1'b0, CG_REG_ADDR, 8'h05);
        wait_idle("rd prefetch idle");
        cpu_op(1'b0, 1'b1, CG_REG_READ, 8'h00);
        step();
        check("rd low", 32'(cpu_rdata), 32'h3C);
        cpu_op(1'b0, 1'b1, CG_REG_READ, 8'h00);
        step();
        check("rd high", 32'(cpu_rdata), 32'h5A);
        wait_idle("rd next prefetch idle");
        cpu_op(1'b0, 1'b1, CG_REG_READ, 8'h00);
        step();
        check("rd 06 low", 32'(cpu_rdata), 32'h34);
        cpu_op(1'b0, 1'b1, CG_REG_READ, 8'h00);
        step();
        check("rd 06 high", 32'(cpu_rdata), 32'h12);
        wait_idle("rd 07 idle");

        // Busy drop: second CGADD lands while the prefetch is pending
        cpu_op(1'b1, 1'b0, CG_REG_ADDR, 8'h80);
        cpu_op(1'b1, 1'b0, CG_REG_ADDR, 8'h90);
        wait_idle("busy idle");
        cpu_op(1'b0, 1'b1, CG_REG_READ, 8'h00);
        step();
        check("busy drop low", 32'(cpu_rdata), 32'h0B);
        cpu_op(1'b0, 1'b1, CG_REG_READ, 8'h00);
        step();
        check("busy drop high", 32'(cpu_rdata), 32'h0A);
        wait_idle("busy rd idle");

        // Collisions: write wins, read dropped
        cpu_op(1'b1, 1'b0, CG_REG_ADDR, 8'h90);
        wait_idle("coll prefetch idle");
        cpu_op(1'b1, 1'b1, CG_REG_READ, 8'h55);
        step();
        check("coll rdata kept", 32'(cpu_rdata), 32'h0A);
        check("coll not busy", 32'(cpu_busy), 32'd0);
        cpu_op(1'b0, 1'b1, CG_REG_READ, 8'h00);
        step();
        check("coll flip kept", 32'(cpu_rdata), 32'h0D);
        cpu_op(1'b0, 1'b1, CG_REG_READ, 8'h00);
        step();
        check("coll high", 32'(cpu_rdata), 32'h0C);
        wait_idle("coll rd idle");
        cpu_op(1'b1, 1'b1, CG_REG_DATA, 8'h77);
        cpu_op(1'b1, 1'b0, CG_REG_DATA, 8'h03);
        wait_idle("coll wr idle");
        check("coll wr addr", 32'(wr_addr), 32'h91);
        check("coll wr data", 32'(wr_data), 32'h0377);

        check("no cg_we outside slot 2", 32'(wr_bad), 32'd0);

        // Reset while a WRITE waits for its slot-2 grant
        disp_req = 1'b1;
        repeat (8) step();
        cpu_op(1'b1, 1'b0, CG_REG_DATA, 8'h66);
        for (int i = 0; i < 8 && tb_slot != SLOT_CPU; i++)
            step();
        cpu_op(1'b1, 1'b0, CG_REG_DATA, 8'h01);
        check("mid-op queued", 32'(cpu_busy), 32'd1);
        nwr = wr_count;
        reset_n = 1'b0;
        step();
        check("midrst main_color", 32'(main_color), 32'h0);
        check("midrst sub_color", 32'(sub_color), 32'h0);
        check("midrst color_valid", 32'(color_valid), 32'h0);
        check("midrst cpu_rdata", 32'(cpu_rdata), 32'h0);
        check("midrst cpu_busy", 32'(cpu_busy), 32'h0);
        check("midrst cg_addr", 32'(cg_addr), 32'h0);
        check("midrst cg_we", 32'(cg_we), 32'h0);
        check("midrst cg_wdata", 32'(cg_wdata), 32'h0);
        step();
        reset_n = 1'b1;
        repeat (12) step();
        check("midrst write abandoned", 32'(wr_count - nwr), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
